chu_adc_sampler_core: RTL and testbench

Parametrised multi-channel ADC sampler slot core for the FPro MMIO bus. It is the successor to the fixed XADC slot:
- A programmable prescaler triggers scans over a runtime channel-enable mask.
- Conversions go to an external converter through a start/done handshake.
- Tagged samples are buffered in a FIFO that software drains over the standard slot interface.
- An interrupt is raised on a FIFO threshold or on overflow.

---
 rtl/chu_adc_sampler_core_if.sv | 32 +++
 rtl/chu_adc_sampler_core.sv | 221 ++++++++++++++++++++++
 tb/tb_chu_adc_sampler_core.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chu_adc_sampler_core_if.sv
// Slot bus and converter handshake bundle for chu_adc_sampler_core.
// slave: core side (rd_data, conv_start/ch, irq out); master: CPU bus + converter side.
interface chu_adc_sampler_core_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              cs;
    logic              read;
    logic              write;
    logic [4:0]        addr;
    logic [31:0]       wr_data;
    logic [31:0]       rd_data;
    logic              conv_start;
    logic [CH_W-1:0]   conv_ch;
    logic [DATA_W-1:0] conv_data;
    logic              conv_done;
    logic              irq;

    modport slave (
        input  cs, read, write, addr, wr_data,
        input  conv_data, conv_done,
        output rd_data, conv_start, conv_ch, irq
    );

    modport master (
        output cs, read, write, addr, wr_data,
        output conv_data, conv_done,
        input  rd_data, conv_start, conv_ch, irq
    );
endinterface

// File: rtl/chu_adc_sampler_core.sv
// Multi-channel ADC sampler slot: prescaled scans, start/done converter, sample FIFO, irq.
// Ports: clk, reset (async active-low), bus (slot regs + converter handshake, slave modport).
module chu_adc_sampler_core #(
    parameter int N_CH           = 4,
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH_BIT = 4,
    parameter int PRE_W          = 16
) (
    input  logic clk,
    input  logic reset,
    chu_adc_sampler_core_if.slave bus
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int FB    = FIFO_DEPTH_BIT;
    localparam int DEPTH = 1 << FB;
    localparam int ENT_W = 4 + DATA_W;
    localparam int MW    = (N_CH > 8) ? 8 : N_CH;
    localparam logic [FB:0] L_FULL = (FB+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;
    localparam logic [1:0] S_NEXT = 2'd3;

    logic [1:0]       r_state;
    logic [CH_W-1:0]  r_ch;
    logic             r_start;
    logic             r_en;
    logic             r_single;
    logic [N_CH-1:0]  r_mask;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] r_pcnt;
    logic [FB:0]      r_th;
    logic [FB-1:0]    r_wp;
    logic [FB-1:0]    r_rp;
    logic [FB:0]      r_count;
    logic             r_ovf;
    logic             r_irq;
    logic [ENT_W-1:0] r_mem [DEPTH];

    logic w_wr, w_wr_ctrl, w_wr_pre, w_wr_th, w_wr_pop, w_wr_ovf;
    logic w_abort, w_tick, w_push, w_push_ok, w_pop, w_clr;
    logic w_empty, w_full;
    logic [CH_W-1:0]  w_first, w_nxt;
    logic             w_first_ok, w_nxt_ok;
    logic [ENT_W-1:0] w_head;
    logic [31:0]      w_rd;
    logic             w_unused;

    assign w_wr      = bus.cs & bus.write;
    assign w_wr_ctrl = w_wr & (bus.addr == 5'd0);
    assign w_wr_pre  = w_wr & (bus.addr == 5'd1);
    assign w_wr_th   = w_wr & (bus.addr == 5'd2);
    assign w_wr_pop  = w_wr & (bus.addr == 5'd3);
    assign w_wr_ovf  = w_wr & (bus.addr == 5'd4);

    // Disabling beats everything, including a result landing this cycle.
    assign w_abort = w_wr_ctrl & ~bus.wr_data[0];
    assign w_tick  = r_en & (r_pcnt == r_pre);
    assign w_push  = (r_state == S_CONV) & bus.conv_done & ~w_abort;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == L_FULL);
    assign w_pop     = w_wr_pop & ~w_empty;
    assign w_clr     = w_wr_ctrl & bus.wr_data[2];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = w_push & (~w_full | w_pop);

    // Lowest enabled channel overall, and lowest enabled above r_ch.
    always_comb begin
        w_first    = '0;
        w_first_ok = 1'b0;
        w_nxt      = '0;
        w_nxt_ok   = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_first    = CH_W'(i);
                w_first_ok = 1'b1;
            end
            if (r_mask[i] && (i > int'(r_ch))) begin
                w_nxt    = CH_W'(i);
                w_nxt_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_start  <= 1'b0;
            r_en     <= 1'b0;
            r_single <= 1'b0;
            r_mask   <= '0;
        end else begin
            r_start <= 1'b0;
            if (w_wr_ctrl) begin
                r_en     <= bus.wr_data[0];
                r_single <= bus.wr_data[1];
                r_mask   <= bus.wr_data[8 +: N_CH];
            end
            if (w_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_wr_ctrl || r_en)
                            r_state <= S_ARM;
                    end
                    S_ARM: begin
                        if (w_tick && w_first_ok) begin
                            r_state <= S_CONV;
                            r_ch    <= w_first;
                            r_start <= 1'b1;
                        end
                    end
                    S_CONV: begin
                        if (bus.conv_done)
                            r_state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (w_nxt_ok) begin
                            r_state <= S_CONV;
                            r_ch    <= w_nxt;
                            r_start <= 1'b1;
                        end else if (r_single) begin
                            r_state <= S_IDLE;
                            if (!w_wr_ctrl)
                                r_en <= 1'b0;
                        end else begin
                            r_state <= S_ARM;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre  <= '0;
            r_th   <= '0;
            r_pcnt <= '0;
        end else begin
            if (w_wr_pre)
                r_pre <= bus.wr_data[PRE_W-1:0];
            if (w_wr_th)
                r_th <= bus.wr_data[FB:0];
            if (!r_en || w_wr_pre || w_tick)
                r_pcnt <= '0;
            else
                r_pcnt <= r_pcnt + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_clr) begin
                r_wp    <= '0;
                r_rp    <= '0;
                r_count <= '0;
            end else begin
                if (w_push_ok)
                    r_wp <= r_wp + FB'(1);
                if (w_pop)
                    r_rp <= r_rp + FB'(1);
                if (w_push_ok && !w_pop)
                    r_count <= r_count + (FB+1)'(1);
                else if (!w_push_ok && w_pop)
                    r_count <= r_count - (FB+1)'(1);
            end
            if (w_push && !w_push_ok && !w_clr)
                r_ovf <= 1'b1;
            else if (w_wr_ovf && bus.wr_data[0])
                r_ovf <= 1'b0;
            r_irq <= r_ovf | ((r_th != '0) & (r_count >= r_th));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !w_clr)
            r_mem[r_wp] <= {4'(r_ch), bus.conv_data};
    end

    always_comb begin
        w_rd   = '0;
        w_head = r_mem[r_rp];
        case (bus.addr)
            5'd0: begin
                w_rd[0]         = w_empty;
                w_rd[1]         = w_full;
                w_rd[2]         = r_ovf;
                w_rd[3]         = (r_state == S_CONV);
                w_rd[8 +: FB+1] = r_count;
                w_rd[16 +: MW]  = r_mask[MW-1:0];
            end
            5'd3: begin
                if (!w_empty) begin
                    w_rd[31:28]       = w_head[ENT_W-1 -: 4];
                    w_rd[DATA_W-1:0] = w_head[DATA_W-1:0];
                end
            end
            default: ;
        endcase
    end

    assign bus.rd_data    = w_rd;
    assign bus.conv_start = r_start;
    assign bus.conv_ch    = r_ch;
    assign bus.irq        = r_irq;

    // Reads have no side effects; the strobe and spare data bits go nowhere.
    assign w_unused = &{1'b0, bus.read, bus.wr_data};
endmodule

// File: tb/tb_chu_adc_sampler_core.sv
// Self-checking bench for chu_adc_sampler_core: scoreboard of expected FIFO entries.
// Converter model answers each conv_start with 0x100+ch after a fixed latency.
module tb_chu_adc_sampler_core;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    chu_adc_sampler_core_if #(.N_CH(4), .DATA_W(16)) bus();

    chu_adc_sampler_core #(
        .N_CH(4), .DATA_W(16), .FIFO_DEPTH_BIT(4), .PRE_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_pass = 0;
    int n_chk = 0;
    logic [31:0] exp_q [$];
    int done_cnt = 0;
    bit m_busy = 1'b0;
    int lat = 5;
    logic [1:0] m_ch;

    initial begin
        bus.conv_done = 1'b0;
        bus.conv_data = '0;
        forever begin
            @(negedge clk);
            if (bus.conv_start === 1'b1) begin
                m_busy = 1'b1;
                m_ch = bus.conv_ch;
                repeat (lat) @(negedge clk);
                bus.conv_data = 16'h100 + 16'(m_ch);
                bus.conv_done = 1'b1;
                done_cnt++;
                @(negedge clk);
                bus.conv_done = 1'b0;
                m_busy = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cs = 1'b1;
        bus.write = 1'b1;
        bus.addr = a;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.cs = 1'b0;
        bus.write = 1'b0;
        bus.addr = 5'd0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rd_data;
    endtask

    task automatic wait_model_idle();
        int t = 0;
        while (m_busy && t < 100) begin
            cyc(1);
            t++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        int n;
        bus.cs = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.addr = 5'd0;
        bus.wr_data = '0;
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        rd(5'd0, v);
        n_chk++;
        if (v !== 32'h1) $display("FAIL reset_status got %h want %h", v, 32'h1);
        else n_pass++;
        rd(5'd3, v);
        n_chk++;
        if (v !== 32'h0) $display("FAIL reset_head got %h want %h", v, 32'h0);
        else n_pass++;
        rd(5'd7, v);
        n_chk++;
        if (v !== 32'h0) $display("FAIL reset_unmapped got %h want %h", v, 32'h0);
        else n_pass++;
        n_chk++;
        if (bus.irq !== 1'b0 || bus.conv_ch !== 2'd0)
            $display("FAIL reset_outputs got irq=%b ch=%0d want 0 0", bus.irq, bus.conv_ch);
        else n_pass++;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (bus.conv_start !== 1'b0) n++;
        end
        n_chk++;
        if (n !== 0) $display("FAIL reset_no_start got %0d want 0", n);
        else n_pass++;
    endtask

    task automatic test_scan();
        logic [31:0] v, e;
        int n, m, k;
        wr(5'd1, 32'd9);
        exp_q.push_back(32'h1000_0101);
        exp_q.push_back(32'h3000_0103);
        wr(5'd0, 32'h0000_0A01);
        n = 0;
        while (bus.conv_start !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        n_chk++;
        if (n != 10 || bus.conv_ch !== 2'd1)
            $display("FAIL scan_first_start got lat=%0d ch=%0d want 10 1", n, bus.conv_ch);
        else n_pass++;
        cyc(1);
        m = 1;
        while (bus.conv_start !== 1'b1 && m < 100) begin
            cyc(1);
            m++;
        end
        n_chk++;
        if (m != 7 || bus.conv_ch !== 2'd3)
            $display("FAIL scan_next_start got gap=%0d ch=%0d want 7 3", m, bus.conv_ch);
        else n_pass++;
        cyc(1);
        k = 1;
        while (bus.conv_start !== 1'b1 && k < 100) begin
            cyc(1);
            k++;
        end
        n_chk++;
        if (((m + k) % 10) != 0 || k >= 100 || bus.conv_ch !== 2'd1)
            $display("FAIL scan_repeat got period=%0d ch=%0d want multiple of 10, ch 1",
                     m + k, bus.conv_ch);
        else n_pass++;
        wr(5'd0, 32'h0);
        wait_model_idle();
        cyc(2);
        rd(5'd0, v);
        n_chk++;
        if (v[15:8] !== 8'd2) $display("FAIL scan_count got %0d want 2", v[15:8]);
        else n_pass++;
        while (exp_q.size() > 0) begin
            rd(5'd3, v);
            e = exp_q.pop_front();
            n_chk++;
            if (v !== e) $display("FAIL scan_pop got %h want %h", v, e);
            else n_pass++;
            wr(5'd3, 32'h0);
        end
        rd(5'd0, v);
        n_chk++;
        if (v !== 32'h1) $display("FAIL scan_empty got %h want %h", v, 32'h1);
        else n_pass++;
    endtask

    task automatic test_single_shot();
        logic [31:0] v, e;
        int n;
        wr(5'd1, 32'd3);
        for (int i = 0; i < 4; i++)
            exp_q.push_back((32'(i) << 28) | (32'h100 + 32'(i)));
        wr(5'd0, 32'h0000_0F03);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.conv_start === 1'b1) n++;
            cyc(1);
        end
        n_chk++;
        if (n != 4) $display("FAIL single_starts got %0d want 4", n);
        else n_pass++;
        rd(5'd0, v);
        n_chk++;
        if (v[15:0] !== 16'h0400) $display("FAIL single_status got %h want %h", v[15:0], 16'h0400);
        else n_pass++;
        while (exp_q.size() > 0) begin
            rd(5'd3, v);
            e = exp_q.pop_front();
            n_chk++;
            if (v !== e) $display("FAIL single_pop got %h want %h", v, e);
            else n_pass++;
            wr(5'd3, 32'h0);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v, e;
        int base, t;
        wr(5'd1, 32'd0);
        for (int i = 0; i < 16; i++)
            exp_q.push_back((i % 2) != 0 ? 32'h1000_0101 : 32'h0000_0100);
        base = done_cnt;
        wr(5'd0, 32'h0000_0301);
        t = 0;
        while (done_cnt < base + 17 && t < 500) begin
            cyc(1);
            t++;
        end
        n_chk++;
        if (t >= 500) $display("FAIL ovf_wait got %0d dones want 17", done_cnt - base);
        else n_pass++;
        wr(5'd0, 32'h0);
        wait_model_idle();
        cyc(2);
        rd(5'd0, v);
        n_chk++;
        if (v[2:0] !== 3'b110 || v[15:8] !== 8'd16)
            $display("FAIL ovf_status got %h want flags 110 count 16", v[15:0]);
        else n_pass++;
        n_chk++;
        if (bus.irq !== 1'b1) $display("FAIL ovf_irq got %b want 1", bus.irq);
        else n_pass++;
        wr(5'd1, 32'd50);
        wr(5'd0, 32'h0000_0401);
        t = 0;
        while (t < 300) begin
            @(negedge clk);
            #1;
            if (bus.conv_done === 1'b1) break;
            t++;
        end
        n_chk++;
        if (t >= 300) $display("FAIL popdone_wait got timeout want conv_done");
        else n_pass++;
        rd(5'd3, v);
        e = exp_q.pop_front();
        n_chk++;
        if (v !== e) $display("FAIL popdone_head got %h want %h", v, e);
        else n_pass++;
        exp_q.push_back(32'h2000_0102);
        wr(5'd3, 32'h0);
        wr(5'd0, 32'h0);
        rd(5'd0, v);
        n_chk++;
        if (v[15:8] !== 8'd16 || v[2] !== 1'b1)
            $display("FAIL popdone_count got %h want count 16 ovf 1", v[15:0]);
        else n_pass++;
        while (exp_q.size() > 0) begin
            rd(5'd3, v);
            e = exp_q.pop_front();
            n_chk++;
            if (v !== e) $display("FAIL ovf_pop got %h want %h", v, e);
            else n_pass++;
            wr(5'd3, 32'h0);
        end
        rd(5'd0, v);
        n_chk++;
        if (v !== 32'h5) $display("FAIL drained_status got %h want %h", v, 32'h5);
        else n_pass++;
        wr(5'd4, 32'h1);
        rd(5'd0, v);
        n_chk++;
        if (v !== 32'h1) $display("FAIL ovf_cleared got %h want %h", v, 32'h1);
        else n_pass++;
        cyc(1);
        n_chk++;
        if (bus.irq !== 1'b0) $display("FAIL ovf_irq_clear got %b want 0", bus.irq);
        else n_pass++;
    endtask

    task automatic test_threshold();
        logic [31:0] v, e;
        int base, t;
        wr(5'd2, 32'd3);
        wr(5'd1, 32'd1);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h1000_0101);
        exp_q.push_back(32'h2000_0102);
        base = done_cnt;
        wr(5'd0, 32'h0000_0703);
        t = 0;
        while (done_cnt < base + 3 && t < 300) begin
            cyc(1);
            t++;
        end
        rd(5'd0, v);
        n_chk++;
        if (t >= 300 || v[15:8] !== 8'd3 || bus.irq !== 1'b0)
            $display("FAIL th_third_push got count=%0d irq=%b want 3 0", v[15:8], bus.irq);
        else n_pass++;
        cyc(1);
        n_chk++;
        if (bus.irq !== 1'b1) $display("FAIL th_irq_rise got %b want 1", bus.irq);
        else n_pass++;
        rd(5'd3, v);
        e = exp_q.pop_front();
        n_chk++;
        if (v !== e) $display("FAIL th_pop got %h want %h", v, e);
        else n_pass++;
        wr(5'd3, 32'h0);
        n_chk++;
        if (bus.irq !== 1'b1) $display("FAIL th_irq_hold got %b want 1", bus.irq);
        else n_pass++;
        cyc(1);
        n_chk++;
        if (bus.irq !== 1'b0) $display("FAIL th_irq_fall got %b want 0", bus.irq);
        else n_pass++;
        while (exp_q.size() > 0) begin
            rd(5'd3, v);
            e = exp_q.pop_front();
            n_chk++;
            if (v !== e) $display("FAIL th_drain got %h want %h", v, e);
            else n_pass++;
            wr(5'd3, 32'h0);
        end
        wr(5'd2, 32'd0);
    endtask

    task automatic test_abort();
        logic [31:0] v;
        int base, t, n;
        wr(5'd1, 32'd5);
        base = done_cnt;
        wr(5'd0, 32'h0000_0101);
        t = 0;
        while (bus.conv_start !== 1'b1 && t < 100) begin
            cyc(1);
            t++;
        end
        wr(5'd0, 32'h0);
        rd(5'd0, v);
        n_chk++;
        if (t >= 100 || v[3] !== 1'b0)
            $display("FAIL abort_idle got busy=%b wait=%0d want 0", v[3], t);
        else n_pass++;
        t = 0;
        while (done_cnt == base && t < 100) begin
            cyc(1);
            t++;
        end
        cyc(2);
        rd(5'd0, v);
        n_chk++;
        if (v !== 32'h1) $display("FAIL abort_nopush got %h want %h", v, 32'h1);
        else n_pass++;

        wr(5'd1, 32'd5);
        base = done_cnt;
        wr(5'd0, 32'h0000_0101);
        t = 0;
        while (bus.conv_start !== 1'b1 && t < 100) begin
            cyc(1);
            t++;
        end
        reset = 1'b0;
        #2;
        rd(5'd0, v);
        n_chk++;
        if (t >= 100 || v !== 32'h1 || bus.conv_start !== 1'b0)
            $display("FAIL rst_mid got status=%h start=%b want 1 0", v, bus.conv_start);
        else n_pass++;
        reset = 1'b1;
        t = 0;
        while (done_cnt == base && t < 100) begin
            cyc(1);
            t++;
        end
        cyc(2);
        rd(5'd0, v);
        n_chk++;
        if (v !== 32'h1) $display("FAIL rst_nopush got %h want %h", v, 32'h1);
        else n_pass++;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (bus.conv_start !== 1'b0) n++;
        end
        n_chk++;
        if (n != 0) $display("FAIL rst_no_restart got %0d starts want 0", n);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single_shot();
        test_overflow();
        test_threshold();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
